// File: rtl/adcv_count_scheduler_if.sv
// Request/result bundle for adcv_count_scheduler: NCH sample request lanes
// plus a single valid/ready result port.
interface adcv_count_scheduler_if #(
  parameter int FROM    = 16,
  parameter int NCH     = 4,
  parameter int LOG_AVG = 3
);
  localparam int CW  = $clog2(FROM + 1);
  localparam int SW  = CW + LOG_AVG;
  localparam int CHW = $clog2(NCH);

  logic [NCH-1:0]      req_valid;
  logic [NCH-1:0]      req_ready;
  logic [NCH*FROM-1:0] req_data;
  logic                out_valid;
  logic                out_ready;
  logic [CHW-1:0]      out_ch;
  logic [SW-1:0]       out_sum;

  modport master (
    output req_valid, req_data, out_ready,
    input  req_ready, out_valid, out_ch, out_sum
  );

  modport slave (
    input  req_valid, req_data, out_ready,
    output req_ready, out_valid, out_ch, out_sum
  );
endinterface

// File: rtl/adcv_count_scheduler.sv
// Round-robin shared popcount for NCH ADC channels; each channel accumulates
// 2**LOG_AVG popcounts and emits the window sum on a valid/ready port.
module count_ones #(
  parameter int FROM   = 16,
  parameter int DOWNTO = $clog2(FROM + 1)
) (
  input  logic [FROM-1:0]   din,
  output logic [DOWNTO-1:0] ones
);
  // Population count of din
  always_comb begin
    ones = '0;
    for (int i = 0; i < FROM; i++) begin
      ones = ones + DOWNTO'(din[i]);
    end
  end
endmodule

module adcv_count_scheduler #(
  parameter int FROM    = 16,
  parameter int NCH     = 4,
  parameter int LOG_AVG = 3
) (
  input logic                   clk,
  input logic                   reset_n,
  input logic                   clear,
  adcv_count_scheduler_if.slave bus
);
  localparam int CW   = $clog2(FROM + 1);
  localparam int SW   = CW + LOG_AVG;
  localparam int CHW  = $clog2(NCH);
  localparam int CNTW = (LOG_AVG > 0) ? LOG_AVG : 1;
  localparam logic [CNTW-1:0] CNT_LAST = CNTW'((1 << LOG_AVG) - 1);
  localparam logic [CHW-1:0]  RR_INIT  = CHW'(NCH - 1);

  logic [CHW-1:0]  rr_ptr_r;
  logic [SW-1:0]   acc_r [NCH];
  logic [CNTW-1:0] cnt_r [NCH];
  logic            out_valid_r;
  logic [CHW-1:0]  out_ch_r;
  logic [SW-1:0]   out_sum_r;

  logic            found_s;
  logic [CHW-1:0]  grant_s;
  logic [CHW-1:0]  idx_s;
  logic            stall_s;
  logic [NCH-1:0]  req_ready_s;
  logic            accept_s;
  logic [FROM-1:0] data_s;
  logic [CW-1:0]   pop_s;
  logic [SW-1:0]   sum_s;
  logic            win_end_s;

  // Round-robin scan starting one past the last accepted channel
  always_comb begin
    found_s = 1'b0;
    grant_s = '0;
    idx_s   = '0;
    for (int k = 1; k <= NCH; k++) begin
      idx_s = CHW'((int'(rr_ptr_r) + k) % NCH);
      if (!found_s && bus.req_valid[idx_s]) begin
        found_s = 1'b1;
        grant_s = idx_s;
      end else begin
        found_s = found_s;
      end
    end
  end

  // Handshake: no grant while stalled, clearing or held in reset
  always_comb begin
    stall_s     = out_valid_r & ~bus.out_ready;
    req_ready_s = '0;
    if (found_s && !stall_s && !clear && reset_n) begin
      req_ready_s[grant_s] = 1'b1;
    end else begin
      req_ready_s = '0;
    end
    accept_s = |(bus.req_valid & req_ready_s);
  end

  // Granted channel datapath into the shared popcount
  always_comb begin
    data_s    = bus.req_data[int'(grant_s)*FROM +: FROM];
    win_end_s = (cnt_r[grant_s] == CNT_LAST);
    sum_s     = acc_r[grant_s] + SW'(pop_s);
  end

  count_ones #(
    .FROM   (FROM),
    .DOWNTO (CW)
  ) u_count_ones (
    .din  (data_s),
    .ones (pop_s)
  );

  // Arbitration pointer, per-channel accumulators and result register
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rr_ptr_r    <= RR_INIT;
      out_valid_r <= 1'b0;
      out_ch_r    <= '0;
      out_sum_r   <= '0;
      for (int i = 0; i < NCH; i++) begin
        acc_r[i] <= '0;
        cnt_r[i] <= '0;
      end
    end else if (clear) begin
      rr_ptr_r    <= RR_INIT;
      out_valid_r <= 1'b0;
      out_ch_r    <= '0;
      out_sum_r   <= '0;
      for (int i = 0; i < NCH; i++) begin
        acc_r[i] <= '0;
        cnt_r[i] <= '0;
      end
    end else begin
      if (accept_s) begin
        rr_ptr_r <= grant_s;
        if (win_end_s) begin
          acc_r[grant_s] <= '0;
          cnt_r[grant_s] <= '0;
          out_sum_r      <= sum_s;
          out_ch_r       <= grant_s;
          out_valid_r    <= 1'b1;
        end else begin
          acc_r[grant_s] <= sum_s;
          cnt_r[grant_s] <= cnt_r[grant_s] + CNTW'(1);
          if (bus.out_ready) begin
            out_valid_r <= 1'b0;
          end
        end
      end else if (bus.out_ready) begin
        out_valid_r <= 1'b0;
      end
    end
  end

  assign bus.req_ready = req_ready_s;
  assign bus.out_valid = out_valid_r;
  assign bus.out_ch    = out_ch_r;
  assign bus.out_sum   = out_sum_r;
endmodule

// File: tb/tb_adcv_count_scheduler.sv
// Directed bench for adcv_count_scheduler: expected window results queue up as
// stimulus is issued and a monitor pops them on every output handshake.
module tb_adcv_count_scheduler;
  typedef struct packed {
    logic [1:0] ch;
    logic [7:0] sum;
  } exp_t;

  logic clk;
  logic reset_n;
  logic clear;
  int   checks = 0;
  int   errors = 0;
  exp_t exp_q[$];
  exp_t mon_e;

  adcv_count_scheduler_if #(.FROM(16), .NCH(4), .LOG_AVG(3)) bus ();

  adcv_count_scheduler #(.FROM(16), .NCH(4), .LOG_AVG(3)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .clear   (clear),
    .bus     (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input int ch, input int sum);
    exp_t e;
    e.ch  = 2'(ch);
    e.sum = 8'(sum);
    exp_q.push_back(e);
  endtask

  task automatic do_clear();
    clear = 1'b1;
    tick();
    clear = 1'b0;
  endtask

  // Monitor: a result transfers at the next rising edge when valid & ready
  always @(negedge clk) begin
    if (reset_n && bus.out_valid && bus.out_ready) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_result: got ch %0d sum %0d, none expected", bus.out_ch, bus.out_sum);
      end else begin
        mon_e = exp_q.pop_front();
        chk("result_ch", int'(bus.out_ch), int'(mon_e.ch));
        chk("result_sum", int'(bus.out_sum), int'(mon_e.sum));
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not complete, expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    reset_n       = 1'b0;
    clear         = 1'b0;
    bus.req_valid = 4'b0000;
    bus.req_data  = 64'h0;
    bus.out_ready = 1'b1;
    repeat (3) tick();
    reset_n = 1'b1;
    tick();
    chk("reset_out_valid", int'(bus.out_valid), 0);
    chk("reset_out_ch", int'(bus.out_ch), 0);
    chk("reset_out_sum", int'(bus.out_sum), 0);
    chk("reset_req_ready", int'(bus.req_ready), 0);

    // Single channel, 8 x popcount 8
    bus.req_data  = {16'h0000, 16'h0000, 16'h0000, 16'h00FF};
    bus.req_valid = 4'b0001;
    push(0, 64);
    for (int i = 0; i < 8; i++) begin
      #1;
      chk("a_req_ready", int'(bus.req_ready), 1);
      tick();
    end
    chk("a_out_valid", int'(bus.out_valid), 1);
    chk("a_out_ch", int'(bus.out_ch), 0);
    chk("a_out_sum", int'(bus.out_sum), 64);
    bus.req_valid = 4'b0000;
    tick();

    // All channels requesting: strict rotation from channel 0
    do_clear();
    chk("b_cleared_valid", int'(bus.out_valid), 0);
    bus.req_data  = {16'h000F, 16'h0007, 16'h0003, 16'h0001};
    bus.req_valid = 4'b1111;
    push(0, 8);
    push(1, 16);
    push(2, 24);
    push(3, 32);
    for (int i = 0; i < 32; i++) begin
      #1;
      chk("b_rr_ready", int'(bus.req_ready), 1 << (i % 4));
      if (i == 29) begin
        chk("b_first_valid", int'(bus.out_valid), 1);
        chk("b_first_ch", int'(bus.out_ch), 0);
        chk("b_first_sum", int'(bus.out_sum), 8);
      end
      tick();
    end
    bus.req_valid = 4'b0000;
    repeat (2) tick();

    // Output stall blocks grants and holds the result
    do_clear();
    bus.req_data  = {16'h0000, 16'h0000, 16'h0000, 16'h00F0};
    bus.req_valid = 4'b0001;
    bus.out_ready = 1'b0;
    repeat (8) tick();
    for (int i = 0; i < 3; i++) begin
      #1;
      chk("c_stall_ready", int'(bus.req_ready), 0);
      chk("c_stall_valid", int'(bus.out_valid), 1);
      chk("c_stall_ch", int'(bus.out_ch), 0);
      chk("c_stall_sum", int'(bus.out_sum), 32);
      tick();
    end
    push(0, 32);
    bus.out_ready = 1'b1;
    #1;
    chk("c_resume_ready", int'(bus.req_ready), 1);
    tick();
    bus.req_valid = 4'b0000;
    tick();

    // Interleaved ch2 / ch1 windows, other lanes carry junk
    do_clear();
    bus.req_data = {16'hAAAA, 16'hFFFF, 16'h0000, 16'hFFFF};
    push(2, 128);
    push(1, 0);
    for (int i = 0; i < 16; i++) begin
      bus.req_valid = (i % 2 == 0) ? 4'b0100 : 4'b0010;
      #1;
      chk("d_ready", int'(bus.req_ready), (i % 2 == 0) ? 4 : 2);
      tick();
    end
    bus.req_valid = 4'b0000;
    repeat (2) tick();

    // Clear mid-window discards partial accumulation and the in-flight sample
    do_clear();
    bus.req_data  = {16'h0000, 16'h0000, 16'h0000, 16'hFFFF};
    bus.req_valid = 4'b0001;
    repeat (3) tick();
    clear = 1'b1;
    #1;
    chk("e_clear_ready", int'(bus.req_ready), 0);
    tick();
    clear        = 1'b0;
    bus.req_data = {16'h0000, 16'h0000, 16'h0000, 16'h0001};
    push(0, 8);
    repeat (8) tick();
    chk("e_sum_direct", int'(bus.out_sum), 8);
    bus.req_valid = 4'b0000;
    tick();

    // Asynchronous reset while a result is pending
    bus.req_valid = 4'b0001;
    bus.out_ready = 1'b0;
    repeat (8) tick();
    chk("f_pending_valid", int'(bus.out_valid), 1);
    bus.req_valid = 4'b1111;
    #2;
    reset_n = 1'b0;
    #1;
    chk("f_async_valid", int'(bus.out_valid), 0);
    chk("f_async_sum", int'(bus.out_sum), 0);
    chk("f_async_ready", int'(bus.req_ready), 0);
    @(negedge clk);
    #2;
    reset_n       = 1'b1;
    bus.out_ready = 1'b1;
    #1;
    chk("f_first_grant", int'(bus.req_ready), 1);
    tick();
    bus.req_valid = 4'b0000;
    repeat (4) tick();
    chk("scoreboard_drained", exp_q.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
